// File: rtl/i2s_stream_ctrl.sv
// Frame-level controller between the I2S link and the DSP sample streams:
// TX pair FIFO popped once per frame, RX pair capture into a valid/ready holding register.
module i2s_stream_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         sclk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         clear_flags,
    input  logic                         ws,
    input  logic [WIDTH-1:0]             rx_left,
    input  logic [WIDTH-1:0]             rx_right,
    output logic [WIDTH-1:0]             tx_left,
    output logic [WIDTH-1:0]             tx_right,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_left,
    input  logic [WIDTH-1:0]             s_right,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_left,
    output logic [WIDTH-1:0]             m_right,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         underrun,
    output logic                         overrun,
    output logic [1:0]                   state
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FILL_W = $clog2(DEPTH+1);
    localparam logic [FILL_W-1:0] FULL = FILL_W'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    typedef struct packed {
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
    } pair_t;

    pair_t              mem_q [DEPTH];
    pair_t              mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               s_ready_q, s_ready_d;
    logic               ws_q, ws_d;
    logic [1:0]         state_q, state_d;
    pair_t              tx_q, tx_d;
    pair_t              m_q, m_d;
    logic               m_valid_q, m_valid_d;
    logic               underrun_q, underrun_d;
    logic               overrun_q, overrun_d;

    logic               boundary_c, push_c, pop_slot_c, do_pop_c, capture_slot_c;

    // Frame boundary: first cycle ws reads 0 after the right word.
    always_comb begin
        boundary_c     = ws_q & ~ws;
        push_c         = s_valid & s_ready_q;
        pop_slot_c     = enable & boundary_c & ((state_q == SYNC) || (state_q == RUN));
        do_pop_c       = pop_slot_c & (fill_q != '0);
        capture_slot_c = enable & boundary_c & (state_q == RUN);
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ws_d       = ws;
        state_d    = state_q;
        tx_d       = tx_q;
        m_d        = m_q;
        m_valid_d  = m_valid_q;
        underrun_d = underrun_q & ~clear_flags;
        overrun_d  = overrun_q & ~clear_flags;

        if (push_c) begin
            mem_d[wr_ptr_q] = pair_t'({s_left, s_right});
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        // An empty FIFO at a frame boundary sends silence; no bypass of a same-cycle push.
        if (pop_slot_c) begin
            if (do_pop_c) begin
                tx_d     = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                tx_d       = '0;
                underrun_d = 1'b1;
            end
        end

        fill_d = fill_q + FILL_W'(push_c) - FILL_W'(do_pop_c);

        if (capture_slot_c) begin
            if (!m_valid_q || m_ready) begin
                m_d       = pair_t'({rx_left, rx_right});
                m_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE:    if (enable) state_d = SYNC;
            SYNC:    if (boundary_c) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (!enable) begin
            state_d = IDLE;
            tx_d    = '0;
        end

        s_ready_d = (fill_d != FULL);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            s_ready_q  <= 1'b0;
            ws_q       <= 1'b1;
            state_q    <= IDLE;
            tx_q       <= '0;
            m_q        <= '0;
            m_valid_q  <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            s_ready_q  <= s_ready_d;
            ws_q       <= ws_d;
            state_q    <= state_d;
            tx_q       <= tx_d;
            m_q        <= m_d;
            m_valid_q  <= m_valid_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_left  = tx_q.left;
    assign tx_right = tx_q.right;
    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign m_left   = m_q.left;
    assign m_right  = m_q.right;
    assign fill     = fill_q;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;
    assign state    = state_q;

endmodule

// File: tb/tb_i2s_stream_ctrl.sv
// Directed bench for i2s_stream_ctrl: prefill, streaming, underrun, overrun,
// full FIFO, pointer wrap, disable and reset.
module tb_i2s_stream_ctrl;

    logic        sclk = 1'b0;
    logic        rst, enable, clear_flags, ws;
    logic [15:0] rx_left, rx_right, tx_left, tx_right;
    logic        s_valid, s_ready;
    logic [15:0] s_left, s_right;
    logic        m_valid, m_ready;
    logic [15:0] m_left, m_right;
    logic [2:0]  fill;
    logic        underrun, overrun;
    logic [1:0]  state;

    int n_chk = 0;
    int n_bad = 0;

    i2s_stream_ctrl #(.WIDTH(16), .DEPTH(4)) dut (
        .sclk(sclk), .rst(rst), .enable(enable), .clear_flags(clear_flags), .ws(ws),
        .rx_left(rx_left), .rx_right(rx_right), .tx_left(tx_left), .tx_right(tx_right),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .m_valid(m_valid), .m_ready(m_ready), .m_left(m_left), .m_right(m_right),
        .fill(fill), .underrun(underrun), .overrun(overrun), .state(state)
    );

    always #5 sclk = ~sclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    // One frame end: right word, then ws falls; outputs are checked just after the boundary edge.
    task automatic boundary();
        ws = 1'b1;
        tick();
        ws = 1'b0;
        tick();
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear_flags = 1'b0; ws = 1'b1;
        rx_left = '0; rx_right = '0; s_valid = 1'b0; s_left = '0; s_right = '0;
        m_ready = 1'b1;
        tick(); tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd0);
        chk("rst_fill", 32'(fill), 32'd0);
        chk("rst_tx", {tx_left, tx_right}, 32'h0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("sready_after_rst", 32'(s_ready), 32'd1);

        // Prefill in IDLE, then first (partial) frame
        push(16'hdead, 16'hbeef);
        push(16'h1234, 16'h5678);
        chk("prefill_fill", 32'(fill), 32'd2);
        chk("prefill_sready", 32'(s_ready), 32'd1);
        enable = 1'b1;
        tick();
        chk("sync_state", 32'(state), 32'd1);
        rx_left = 16'h0bad; rx_right = 16'hf00d;
        boundary();
        chk("first_tx", {tx_left, tx_right}, 32'hdeadbeef);
        chk("first_mvalid", 32'(m_valid), 32'd0);
        chk("first_state", 32'(state), 32'd2);
        chk("first_fill", 32'(fill), 32'd1);

        // Steady stream with loopback RX
        rx_left = 16'hdead; rx_right = 16'hbeef;
        boundary();
        chk("run_tx", {tx_left, tx_right}, 32'h12345678);
        chk("run_m", {m_left, m_right}, 32'hdeadbeef);
        chk("run_mvalid", 32'(m_valid), 32'd1);
        tick();
        chk("run_mvalid_drop", 32'(m_valid), 32'd0);
        chk("run_flags", {30'd0, underrun, overrun}, 32'd0);

        // Underrun, recovery, clear
        boundary();
        chk("ur_tx", {tx_left, tx_right}, 32'h0);
        chk("ur_flag", 32'(underrun), 32'd1);
        push(16'haaaa, 16'h5555);
        boundary();
        chk("ur_recover_tx", {tx_left, tx_right}, 32'haaaa5555);
        chk("ur_sticky", 32'(underrun), 32'd1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("ur_cleared", 32'(underrun), 32'd0);

        // Overrun: two captures without m_ready
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        m_ready = 1'b0;
        rx_left = 16'ha1a1; rx_right = 16'hb1b1;
        boundary();
        chk("or_first_m", {m_left, m_right}, 32'ha1a1b1b1);
        chk("or_first_tx", {tx_left, tx_right}, 32'h11112222);
        rx_left = 16'hc2c2; rx_right = 16'hd2d2;
        boundary();
        chk("or_flag", 32'(overrun), 32'd1);
        chk("or_keep_m", {m_left, m_right}, 32'ha1a1b1b1);
        chk("or_tx", {tx_left, tx_right}, 32'h33334444);
        ws = 1'b1;
        tick();
        m_ready = 1'b1;
        rx_left = 16'he3e3; rx_right = 16'hf4f4;
        ws = 1'b0;
        tick();
        chk("or_accept_m", {m_left, m_right}, 32'he3e3f4f4);
        chk("or_accept_mvalid", 32'(m_valid), 32'd1);
        tick();
        chk("or_mvalid_drop", 32'(m_valid), 32'd0);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        chk("flags_cleared", {30'd0, underrun, overrun}, 32'd0);

        // Full FIFO
        for (int i = 0; i < 4; i++) push(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        chk("full_fill", 32'(fill), 32'd4);
        chk("full_sready", 32'(s_ready), 32'd0);
        push(16'hffff, 16'hffff);
        chk("full_no_push", 32'(fill), 32'd4);
        boundary();
        chk("full_pop_tx", {tx_left, tx_right}, 32'h10002000);
        chk("full_pop_fill", 32'(fill), 32'd3);
        chk("full_pop_sready", 32'(s_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            boundary();
            chk("drain_tx", {tx_left, tx_right}, {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
        end
        chk("drain_underrun", 32'(underrun), 32'd0);

        // Pointer wrap
        for (int i = 0; i < 9; i++) begin
            push(16'h3000 + 16'(i), 16'h4000 + 16'(i));
            boundary();
            chk("wrap_tx", {tx_left, tx_right}, {16'h3000 + 16'(i), 16'h4000 + 16'(i)});
            chk("wrap_fill", 32'(fill), 32'd0);
        end

        // Disable mid-frame, then reset
        boundary();
        chk("pre_rst_underrun", 32'(underrun), 32'd1);
        push(16'h7777, 16'h8888);
        m_ready = 1'b0;
        boundary();
        chk("pre_dis_tx", {tx_left, tx_right}, 32'h77778888);
        push(16'h9999, 16'haaaa);
        ws = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        chk("dis_state", 32'(state), 32'd0);
        chk("dis_tx", {tx_left, tx_right}, 32'h0);
        chk("dis_fill", 32'(fill), 32'd1);
        chk("dis_mvalid", 32'(m_valid), 32'd1);
        chk("dis_underrun", 32'(underrun), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst2_fill", 32'(fill), 32'd0);
        chk("rst2_mvalid", 32'(m_valid), 32'd0);
        chk("rst2_flags", {30'd0, underrun, overrun}, 32'd0);
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_sready", 32'(s_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
